// File: rtl/nios2_oci_dct_packer_pkg.sv
// Shared constants, FSM state type and atom-placement helper for the OCI trace
// atom packer.
package nios2_oci_dct_packer_pkg;

    localparam int ATOM_W         = 3;
    localparam int ATOMS_PER_WORD = 10;
    localparam int DCT_W          = ATOM_W * ATOMS_PER_WORD;
    localparam int DCT_CNT_W      = 4;
    localparam int IDLE_TIMEOUT   = 64;
    localparam int IDLE_W         = 7;
    localparam int DROP_CNT_W     = 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ENDED = 2'd2
    } pack_state_e;

    // ORs one atom into its slot of a capture word, slot 0 in the LSBs.
    function automatic logic [DCT_W-1:0] place_atom(
        input logic [DCT_W-1:0]     word,
        input logic [ATOM_W-1:0]    atom,
        input logic [DCT_CNT_W-1:0] slot
    );
        logic [DCT_W-1:0] ext;
        ext = {{(DCT_W-ATOM_W){1'b0}}, atom};
        return word | (ext << (ATOM_W * int'(slot)));
    endfunction

endpackage

// File: rtl/nios2_oci_dct_packer_if.sv
// Valid/ready capture-word bus between the packer and its trace sink.
interface nios2_oci_dct_packer_if;

    logic                                            out_valid;
    logic                                            out_ready;
    logic [nios2_oci_dct_packer_pkg::DCT_W-1:0]      dct_buffer;
    logic [nios2_oci_dct_packer_pkg::DCT_CNT_W-1:0]  dct_count;

    modport master (
        output out_valid,
        output dct_buffer,
        output dct_count,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  dct_buffer,
        input  dct_count,
        output out_ready
    );

endinterface

// File: rtl/nios2_oci_dct_outreg.sv
// One-entry valid/ready holding register that drives the capture-word bus.
module nios2_oci_dct_outreg
    import nios2_oci_dct_packer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [DCT_W-1:0]       load_data,
    input  logic [DCT_CNT_W-1:0]   load_count,
    output logic                   free,
    nios2_oci_dct_packer_if.master dct
);

    logic                 valid_q, valid_d;
    logic [DCT_W-1:0]     data_q,  data_d;
    logic [DCT_CNT_W-1:0] count_q, count_d;

    // Load a new word, or retire the current one once the consumer takes it.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            count_d = load_count;
        end else if (dct.out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Holding register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= {DCT_W{1'b0}};
            count_q <= {DCT_CNT_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign free           = ~valid_q | dct.out_ready;
    assign dct.out_valid  = valid_q;
    assign dct.dct_buffer = data_q;
    assign dct.dct_count  = count_q;

endmodule

// File: rtl/nios2_oci_dct_packer.sv
// Packs 3-bit OCI trace atoms into 30-bit capture words, emits them on full,
// flush, idle timeout or end-of-test drain, and reports drops and completion.
module nios2_oci_dct_packer
    import nios2_oci_dct_packer_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   atom_valid,
    input  logic [ATOM_W-1:0]      atom_data,
    input  logic                   flush_req,
    input  logic                   test_ending,
    nios2_oci_dct_packer_if.master dct,
    output logic                   overflow,
    output logic [DROP_CNT_W-1:0]  drop_count,
    output logic                   test_has_ended
);

    pack_state_e           state_q, state_d;
    logic [DCT_W-1:0]      fill_data_q, fill_data_d;
    logic [DCT_CNT_W-1:0]  fill_count_q, fill_count_d;
    logic                  flush_pend_q, flush_pend_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;
    logic                  ended_q, ended_d;

    logic out_free_s;
    logic fill_full_s;
    logic fill_empty_s;
    logic idle_hit_s;
    logic flush_now_s;
    logic xfer_s;
    logic atom_live_s;
    logic accept_s;
    logic drop_s;

    nios2_oci_dct_outreg u_outreg (
        .clk        (clk),
        .rst_n      (reset_n),
        .load       (xfer_s),
        .load_data  (fill_data_q),
        .load_count (fill_count_q),
        .free       (out_free_s),
        .dct        (dct)
    );

    // Per-cycle events: word transfer, atom acceptance and atom drop.
    always_comb begin
        fill_full_s  = (fill_count_q == DCT_CNT_W'(ATOMS_PER_WORD));
        fill_empty_s = (fill_count_q == {DCT_CNT_W{1'b0}});
        idle_hit_s   = (idle_q == IDLE_W'(IDLE_TIMEOUT));
        flush_now_s  = flush_pend_q | flush_req | idle_hit_s | (state_q == DRAIN);
        xfer_s       = out_free_s & (fill_full_s | (flush_now_s & ~fill_empty_s));
        atom_live_s  = atom_valid & enable & (state_q == RUN);
        // A full fill still takes an atom when it is being emptied this cycle.
        accept_s     = atom_live_s & (~fill_full_s | xfer_s);
        drop_s       = atom_live_s & fill_full_s & ~xfer_s;
    end

    // Fill register: restart at slot 0 on transfer, else append.
    always_comb begin
        fill_data_d  = fill_data_q;
        fill_count_d = fill_count_q;
        if (xfer_s) begin
            if (accept_s) begin
                fill_data_d  = place_atom({DCT_W{1'b0}}, atom_data, {DCT_CNT_W{1'b0}});
                fill_count_d = DCT_CNT_W'(1);
            end else begin
                fill_data_d  = {DCT_W{1'b0}};
                fill_count_d = {DCT_CNT_W{1'b0}};
            end
        end else if (accept_s) begin
            fill_data_d  = place_atom(fill_data_q, atom_data, fill_count_q);
            fill_count_d = fill_count_q + DCT_CNT_W'(1);
        end else begin
            fill_data_d  = fill_data_q;
            fill_count_d = fill_count_q;
        end
    end

    // Flush pending latch and idle timer; flushing an empty fill is dropped.
    always_comb begin
        flush_pend_d = flush_now_s & ~fill_empty_s & ~xfer_s;
        idle_d       = idle_q;
        if (xfer_s || accept_s || fill_empty_s) begin
            idle_d = {IDLE_W{1'b0}};
        end else if (enable && !idle_hit_s) begin
            idle_d = idle_q + IDLE_W'(1);
        end else begin
            idle_d = idle_q;
        end
    end

    // Sticky overflow and saturating drop counter.
    always_comb begin
        overflow_d   = overflow_q | drop_s;
        drop_count_d = drop_count_q;
        if (drop_s && (drop_count_q != {DROP_CNT_W{1'b1}})) begin
            drop_count_d = drop_count_q + DROP_CNT_W'(1);
        end else begin
            drop_count_d = drop_count_q;
        end
    end

    // Run / drain / ended sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (test_ending) state_d = DRAIN;
                else             state_d = RUN;
            end
            DRAIN: begin
                if (fill_empty_s && !dct.out_valid) state_d = ENDED;
                else                                state_d = DRAIN;
            end
            ENDED:   state_d = ENDED;
            default: state_d = RUN;
        endcase
        ended_d = ended_q | (state_d == ENDED);
    end

    // Packer state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            fill_data_q  <= {DCT_W{1'b0}};
            fill_count_q <= {DCT_CNT_W{1'b0}};
            flush_pend_q <= 1'b0;
            idle_q       <= {IDLE_W{1'b0}};
            overflow_q   <= 1'b0;
            drop_count_q <= {DROP_CNT_W{1'b0}};
            ended_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_data_q  <= fill_data_d;
            fill_count_q <= fill_count_d;
            flush_pend_q <= flush_pend_d;
            idle_q       <= idle_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            ended_q      <= ended_d;
        end
    end

    assign overflow       = overflow_q;
    assign drop_count     = drop_count_q;
    assign test_has_ended = ended_q;

endmodule
